data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter_pkg.sv | 5 +
 rtl/dmem_arb_pick.sv | 11 +
 rtl/data_memory_arbiter.sv | 85 ++++++++
 tb/tb_data_memory_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared data width and arbiter FSM state encodings.
package data_memory_arbiter_pkg;
    localparam int INTERNAL_BITS = 16;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: 2-way winner select; a tie goes to the requester not granted last.
module dmem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick0,
    output logic pick1
);
    assign pick0 = req0 && (!req1 || last);
    assign pick1 = req1 && (!req0 || !last);
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-requester single-port memory arbiter with lockable bursts.
// DMEM_ARB_RR_EN selects round-robin tie breaking; otherwise requester 0 wins ties.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 13,
    parameter int MAX_BURST = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Req0,
    input  logic                     Req1,
    input  logic                     We0,
    input  logic                     We1,
    input  logic                     Lock0,
    input  logic                     Lock1,
    input  logic [ADDR_BITS-1:0]     Addr0,
    input  logic [ADDR_BITS-1:0]     Addr1,
    input  logic [INTERNAL_BITS-1:0] Wdata0,
    input  logic [INTERNAL_BITS-1:0] Wdata1,
    output logic                     Gnt0,
    output logic                     Gnt1,
    output logic [INTERNAL_BITS-1:0] Rdata,
    output logic                     Rvalid0,
    output logic                     Rvalid1,
    output logic                     Read_enable,
    output logic                     Write_enable,
    output logic [ADDR_BITS-1:0]     Address,
    output logic [INTERNAL_BITS-1:0] Write_data,
    input  logic [INTERNAL_BITS-1:0] Data_out
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
    state_t        state;
    logic [CW-1:0] cnt;
    logic          last, own0, own1, pick0, pick1;
`ifndef DMEM_ARB_RR_EN
    assign last = 1'b1;
`endif
    // an owner still requesting bypasses arbitration entirely
    assign own0 = state == OWN0 && Req0;
    assign own1 = state == OWN1 && Req1;
    dmem_arb_pick u_pick (.req0(Req0), .req1(Req1), .last(last), .pick0(pick0), .pick1(pick1));
    assign Gnt0 = !RST && !own1 && (own0 || pick0);
    assign Gnt1 = !RST && !own0 && (own1 || pick1);
    assign Address      = Gnt0 ? Addr0  : Gnt1 ? Addr1  : '0;
    assign Write_data   = Gnt0 ? Wdata0 : Gnt1 ? Wdata1 : '0;
    assign Write_enable = Gnt0 ? We0    : Gnt1 ? We1    : 1'b0;
    assign Read_enable  = Gnt0 ? !We0   : Gnt1 ? !We1   : 1'b0;
    assign Rdata        = Data_out;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            Rvalid0 <= 1'b0;
            Rvalid1 <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last    <= 1'b1;
`endif
        end else begin
            Rvalid0 <= Gnt0 && !We0;
            Rvalid1 <= Gnt1 && !We1;
`ifdef DMEM_ARB_RR_EN
            if (Gnt0 || Gnt1) last <= Gnt1;
`endif
            if (own0 || own1) begin
                if ((own0 ? Lock0 : Lock1) && cnt + CW'(1) < MAXC) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else if (Gnt0 && Lock0 && MAX_BURST > 1) begin
                state <= OWN0;
                cnt   <= CW'(1);
            end else if (Gnt1 && Lock1 && MAX_BURST > 1) begin
                state <= OWN1;
                cnt   <= CW'(1);
            end else begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: randomized scoreboard bench against a transaction-level arbiter model.
module tb_data_memory_arbiter;
    localparam int AW = 6;
    localparam int MB = 4;
    localparam int DW = data_memory_arbiter_pkg::INTERNAL_BITS;
    typedef struct {int cyc; int who; logic we; logic [AW-1:0] addr; logic [DW-1:0] wd;} g_t;
    typedef struct {int cyc; int who; logic [DW-1:0] data;} r_t;
    logic CLK = 0, RST = 1;
    logic Req0 = 0, Req1 = 0, We0 = 0, We1 = 0, Lock0 = 0, Lock1 = 0;
    logic [AW-1:0] Addr0 = 0, Addr1 = 0, Address;
    logic [DW-1:0] Wdata0 = 0, Wdata1 = 0, Rdata, Write_data, Data_out;
    logic Gnt0, Gnt1, Rvalid0, Rvalid1, Read_enable, Write_enable;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    g_t gq[$];
    r_t rq[$];
    int cyc = 0, vectors = 0, miscompares = 0;
    data_memory_arbiter #(.ADDR_BITS(AW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Lock0(Lock0), .Lock1(Lock1), .Addr0(Addr0), .Addr1(Addr1),
        .Wdata0(Wdata0), .Wdata1(Wdata1), .Gnt0(Gnt0), .Gnt1(Gnt1), .Rdata(Rdata),
        .Rvalid0(Rvalid0), .Rvalid1(Rvalid1), .Read_enable(Read_enable),
        .Write_enable(Write_enable), .Address(Address), .Write_data(Write_data),
        .Data_out(Data_out));
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    // external memory with registered read, read-before-write
    always @(posedge CLK) begin
        if (Read_enable) Data_out <= mem[Address];
        if (Write_enable) mem[Address] <= Write_data;
    end
    always @(negedge CLK) begin
        g_t e;
        r_t r;
        vectors++;
        if (Gnt0 && Gnt1) begin
            miscompares++;
            $display("FAIL onehot cyc=%0d got gnt=11 required at most one", cyc);
        end
        if (Gnt0 || Gnt1) begin
            vectors++;
            if (gq.size() == 0) begin
                miscompares++;
                $display("FAIL grant cyc=%0d got gnt=%b%b required none", cyc, Gnt1, Gnt0);
            end else begin
                e = gq.pop_front();
                if (e.cyc != cyc || e.who != int'(Gnt1) || Address != e.addr || Write_enable != e.we
                    || Read_enable != !e.we || Write_data != e.wd) begin
                    miscompares++;
                    $display("FAIL grant got cyc=%0d who=%0d addr=%0h we=%b re=%b wd=%h required cyc=%0d who=%0d addr=%0h we=%b wd=%h",
                             cyc, Gnt1, Address, Write_enable, Read_enable, Write_data, e.cyc, e.who, e.addr, e.we, e.wd);
                end
            end
        end else if (Read_enable || Write_enable || Address != '0 || Write_data != '0) begin
            miscompares++;
            $display("FAIL idle cyc=%0d got re=%b we=%b addr=%0h wd=%h required all zero",
                     cyc, Read_enable, Write_enable, Address, Write_data);
        end
        if (Rvalid0 || Rvalid1) begin
            vectors++;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid cyc=%0d got rv=%b%b required none", cyc, Rvalid1, Rvalid0);
            end else begin
                r = rq.pop_front();
                if (r.cyc != cyc || Rvalid0 == Rvalid1 || r.who != int'(Rvalid1) || Rdata != r.data) begin
                    miscompares++;
                    $display("FAIL rdata got cyc=%0d rv=%b%b data=%h required cyc=%0d who=%0d data=%h",
                             cyc, Rvalid1, Rvalid0, Rdata, r.cyc, r.who, r.data);
                end
            end
        end
    end
    initial begin
        logic pend [2], we [2], lk [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        int owner, burst, last, w, rate, lkpct;
        logic rst;
        owner = -1; burst = 0; last = 1;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = DW'(i * 37 + 5);
            ref_mem[i] = DW'(i * 37 + 5);
        end
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; we[r] = 0; lk[r] = 0; ad[r] = 0; wd[r] = 0;
        end
        for (int n = 0; n < 3100; n++) begin
            @(posedge CLK);
            #1;
            rate  = n < 1000 ? 50 : n < 2000 ? 100 : 60;
            lkpct = n < 1000 ? 30 : n < 2000 ? 90 : 50;
            rst = n < 2 || (n >= 2000 && n < 3000 && $urandom_range(99) < 3);
            for (int r = 0; r < 2; r++)
                if (!pend[r] && n < 3000 && $urandom_range(99) < rate) begin
                    pend[r] = 1;
                    we[r] = 1'($urandom);
                    ad[r] = AW'($urandom_range(15));
                    wd[r] = DW'($urandom);
                    lk[r] = $urandom_range(99) < lkpct;
                end
            RST = rst;
            Req0 = pend[0]; We0 = pend[0] & we[0]; Lock0 = pend[0] & lk[0];
            Addr0 = pend[0] ? ad[0] : '0; Wdata0 = pend[0] ? wd[0] : '0;
            Req1 = pend[1]; We1 = pend[1] & we[1]; Lock1 = pend[1] & lk[1];
            Addr1 = pend[1] ? ad[1] : '0; Wdata1 = pend[1] ? wd[1] : '0;
            w = -1;
            if (rst) begin
                owner = -1; burst = 0; last = 1;
            end else if (owner >= 0 && pend[owner]) begin
                w = owner;
                burst++;
                if (!lk[w] || burst == MB) begin owner = -1; burst = 0; end
            end else begin
                owner = -1; burst = 0;
`ifdef DMEM_ARB_RR_EN
                if (pend[0] && pend[1]) w = 1 - last;
`else
                if (pend[0] && pend[1]) w = 0;
`endif
                else if (pend[0]) w = 0;
                else if (pend[1]) w = 1;
                if (w >= 0 && lk[w] && MB > 1) begin owner = w; burst = 1; end
            end
            if (w >= 0) begin
                last = w;
                gq.push_back('{cyc, w, we[w], ad[w], wd[w]});
                if (we[w]) ref_mem[ad[w]] = wd[w];
                else rq.push_back('{cyc + 1, w, ref_mem[ad[w]]});
                pend[w] = 0;
            end
        end
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if (gq.size() != 0 || rq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got grants=%0d reads=%0d outstanding required 0", gq.size(), rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
